// File: rtl/d_mem_lsu.sv
// Load/store unit with one request in flight: drives d_mem's word port and returns one response pulse per request.
// Optional macro DMEM_MISALIGN_SPLIT_EN splits word-crossing accesses into two word accesses.
module d_mem_lsu #(
  parameter int MEM_SIZE_WORDS = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_fault,
  output logic [31:0] mem_addr,
  output logic        mem_wr_en,
  output logic [31:0] mem_wr_data,
  output logic [3:0]  mem_byte_en,
  input  logic [31:0] mem_rd_data
);
  typedef enum logic [2:0] {IDLE, ACC1, ACC2, RD, RESP} state_t;

  localparam logic [31:0] MEM_WORDS = 32'(MEM_SIZE_WORDS);

  state_t      state_reg, state_next;
  logic [31:0] addr_reg, word0_reg, word1_reg;
  logic [63:0] data_reg;
  logic [7:0]  mask_reg;
  logic [1:0]  size_reg;
  logic        we_reg, unsigned_reg, fault_reg, split_reg;

  logic [3:0]  req_base;
  logic [7:0]  req_mask;
  logic [31:0] req_word;
  logic        req_misaligned, req_split, req_fault;
  logic [31:0] ld_shift, ld_data;
  logic        wr_en_raw;

  // Decode the incoming request: lane mask over two words, split and fault.
  always_comb begin
    case (req_size)
      2'b00:   req_base = 4'b0001;
      2'b01:   req_base = 4'b0011;
      2'b10:   req_base = 4'b1111;
      default: req_base = 4'b0000;
    endcase
    req_mask = {4'b0000, req_base} << req_addr[1:0];
    req_misaligned = (req_size == 2'b01 && req_addr[0]) ||
                     (req_size == 2'b10 && req_addr[1:0] != 2'b00);
    req_word = {2'b00, req_addr[31:2]};
`ifdef DMEM_MISALIGN_SPLIT_EN
    req_split = req_misaligned && (req_mask[7:4] != 4'b0000);
    req_fault = (req_size == 2'b11);
`else
    req_split = 1'b0;
    req_fault = (req_size == 2'b11) || req_misaligned;
`endif
    if (req_word >= MEM_WORDS || (req_split && (req_word + 32'd1) >= MEM_WORDS))
      req_fault = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      addr_reg     <= '0;
      size_reg     <= '0;
      we_reg       <= 1'b0;
      unsigned_reg <= 1'b0;
      fault_reg    <= 1'b0;
      split_reg    <= 1'b0;
      mask_reg     <= '0;
      data_reg     <= '0;
      word0_reg    <= '0;
      word1_reg    <= '0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: if (req_valid) begin
          addr_reg     <= req_addr;
          size_reg     <= req_size;
          we_reg       <= req_we;
          unsigned_reg <= req_unsigned;
          fault_reg    <= req_fault;
          split_reg    <= req_split;
          mask_reg     <= req_mask;
          data_reg     <= req_we ? ({32'd0, req_wdata} << {req_addr[1:0], 3'b000}) : 64'd0;
          word0_reg    <= '0;
          word1_reg    <= '0;
        end
        // Read data lags the presented address by one cycle.
        ACC2: if (!we_reg) word0_reg <= mem_rd_data;
        RD: begin
          if (split_reg) word1_reg <= mem_rd_data;
          else           word0_reg <= mem_rd_data;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    ld_shift = 32'({word1_reg, word0_reg} >> {addr_reg[1:0], 3'b000});
    case (size_reg)
      2'b00:   ld_data = {{24{~unsigned_reg & ld_shift[7]}}, ld_shift[7:0]};
      2'b01:   ld_data = {{16{~unsigned_reg & ld_shift[15]}}, ld_shift[15:0]};
      default: ld_data = ld_shift;
    endcase
  end

  always_comb begin
    state_next  = state_reg;
    req_ready   = 1'b0;
    rsp_valid   = 1'b0;
    rsp_fault   = 1'b0;
    rsp_rdata   = '0;
    mem_addr    = '0;
    wr_en_raw   = 1'b0;
    mem_wr_data = '0;
    mem_byte_en = '0;
    case (state_reg)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_next = req_fault ? RESP : ACC1;
      end
      ACC1: begin
        mem_addr    = {addr_reg[31:2], 2'b00};
        wr_en_raw   = we_reg;
        mem_wr_data = data_reg[31:0];
        mem_byte_en = we_reg ? mask_reg[3:0] : 4'b1111;
        if (split_reg)   state_next = ACC2;
        else if (we_reg) state_next = RESP;
        else             state_next = RD;
      end
      ACC2: begin
        mem_addr    = {addr_reg[31:2], 2'b00} + 32'd4;
        wr_en_raw   = we_reg;
        mem_wr_data = data_reg[63:32];
        mem_byte_en = we_reg ? mask_reg[7:4] : 4'b1111;
        state_next  = we_reg ? RESP : RD;
      end
      RD: state_next = RESP;
      RESP: begin
        rsp_valid  = 1'b1;
        rsp_fault  = fault_reg;
        rsp_rdata  = (fault_reg || we_reg) ? 32'd0 : ld_data;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // No write may commit while reset is asserted, even mid-access.
  assign mem_wr_en = wr_en_raw & ~rst;

endmodule

// File: doc/d_mem_lsu.md
Name: d_mem_lsu

Overview:
Load/store initiator that sits between the core's memory stage and d_mem, driving d_mem's addr / wr_en / wr_data / byte_en port and consuming its rd_data. Accepts one load or store request at a time via a valid/ready handshake. Generates word-aligned addresses, byte enables and lane-shifted write data. Aligns and sign/zero-extends load data and returns a single-cycle response pulse.

Parameters:
MEM_SIZE_WORDS, 16, number of 32-bit words in the attached d_mem; word index >= this faults.

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
req_valid  in  1  request present
req_ready  out  1  block can accept; high only in IDLE
req_we  in  1  1 = store, 0 = load
req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
req_unsigned  in  1  load zero-extend (1) or sign-extend (0); ignored for stores
req_addr  in  32  byte address
req_wdata  in  32  store data, LSB-justified
rsp_valid  out  1  one-cycle response pulse; consumer must accept, no back-pressure
rsp_rdata  out  32  extended load data; 0 for stores and faults
rsp_fault  out  1  misaligned, illegal size or out-of-range; qualified by rsp_valid
mem_addr  out  32  to d_mem addr, always word-aligned (bits[1:0]=00)
mem_wr_en  out  1  to d_mem wr_en
mem_wr_data  out  32  to d_mem wr_data, lane-shifted
mem_byte_en  out  4  to d_mem byte_en
mem_rd_data  in  32  from d_mem rd_data; valid the cycle after mem_addr is presented

Behaviour:
- Reset: state=IDLE; req_ready=1; rsp_valid=0, rsp_fault=0, rsp_rdata=0; mem_wr_en=0, mem_addr=0, mem_wr_data=0, mem_byte_en=0.
- mem_wr_en is the registered enable ANDed with ~rst, so no write commits in any cycle where rst is high. Reset mid-operation abandons the request with no response and returns to IDLE.
- off = req_addr[1:0]. Base mask: byte 0001, half 0011, word 1111.
- Lane mapping: 8-bit lane mask = base<<off; 64-bit data = req_wdata<<(8*off).
  - Low word uses mask[3:0] and data[31:0].
  - High word uses mask[7:4] and data[63:32].
- Misaligned: half with off[0]=1, or word with off!=0.
- Fault conditions: illegal size; misaligned (when the optional feature is absent); any touched word index (addr>>2, plus +1 for split) >= MEM_SIZE_WORDS.
  - A fault issues no memory access.
  - FAULT response: rsp_valid=1, rsp_fault=1, rsp_rdata=0 at T+1 (T = acceptance cycle).
- FSM states: IDLE, ACC1, ACC2, RD, RESP.
  - IDLE --(req_valid & req_ready)--> latch request; go to FAULT-RESP, or to ACC1.
  - ACC1: mem_addr = addr&~3, low-word byte_en/data. mem_wr_en=1 if store.
    - Store: go to ACC2 if split, else RESP.
    - Load: go to ACC2 if split, else RD.
  - ACC2 (split only): mem_addr = base+4, computed modulo 2^32; high-word byte_en/data. A load captures word0 from mem_rd_data. Store goes to RESP, load goes to RD.
  - RD: capture last word (word0 for aligned, word1 for split); go to RESP.
  - RESP: rsp_valid=1 for one cycle; go to IDLE.
- Loads drive mem_byte_en=1111 and mem_wr_en=0.
- Load data: {word1,word0}>>(8*off), truncated to size, then extended per req_unsigned.
- Latency from acceptance T to rsp_valid:
  - aligned store T+2
  - aligned load T+3
  - split store T+3
  - split load T+4
  - fault T+1
- req_ready=0 outside IDLE; requests presented then are not accepted and must be held.

Optional Feature:
DMEM_MISALIGN_SPLIT_EN.
- Defined: misaligned half/word accesses crossing a word boundary are split into two word accesses (ACC1 then ACC2). Misaligned accesses within one word (e.g. half at off=1) use ACC1 only with shifted mask.
- Undefined: every misaligned access faults; ACC2 is unreachable and may be removed.

Test Plan:
1. Store word 0xDEADBEEF at addr 0 -> one cycle of mem_wr_en=1, mem_addr=0, mem_byte_en=1111, mem_wr_data=0xDEADBEEF; rsp_valid at T+2 with rsp_fault=0.
2. Memory word0=0xDEADBEEF; load byte addr 3 signed -> rsp_rdata=0xFFFFFFDE at T+3; unsigned -> 0x000000DE.
3. Store half 0x00005678 at addr 6 -> mem_addr=4, byte_en=1100, wr_data=0x56780000; then load half unsigned addr 6 -> 0x00005678.
4. Store word 0xCAFEBABE at addr 2:
   - without macro: rsp_fault=1 at T+1, mem_wr_en never high.
   - with macro: addr 0, be 1100, data 0xBABE0000; then addr 4, be 0011, data 0x0000CAFE; rsp at T+3.
5. With macro, word0=0xDEADBEEF, word1=0x11223344; load word addr 1 -> rsp_rdata=0x44DEADBE at T+4, rsp_fault=0.
6. Load word addr 64 with MEM_SIZE_WORDS=16 -> fault at T+1. Store accepted then rst high during ACC1 -> mem_wr_en=0 that cycle, no rsp_valid, req_ready=1 after reset.
